// File: rtl/shared_bus_xfer_if.sv
// rtl/shared_bus_xfer_if.sv - grant, client and shared-bus signal bundle for shared_bus_xfer
//
// Signals:
//   gnt        one-hot grant from the arbiter, bit i = client i
//   cdata      client data, client i at [i*DW +: DW]
//   clen       client burst length (beats-1), client i at [i*LENW +: LENW]
//   bus_valid  shared bus beat valid
//   bus_data   shared bus data, 0 while bus_valid is low
//   bus_src    index of the client owning the current burst
//   bus_last   final beat of the burst
//   bus_ready  shared bus sink ready
//   beat_ack   one-hot per-beat acknowledge back to the owning client
//   done       one-hot one-cycle burst-complete pulse
//   busy       transfer engine not idle
//   err        one-cycle pulse on illegal grant or abort
// Modports: master = transfer engine, slave = clients/arbiter/sink side.
interface shared_bus_xfer_if #(
    parameter int DW   = 8,
    parameter int LENW = 4
);
    logic [3:0]        gnt;
    logic [4*DW-1:0]   cdata;
    logic [4*LENW-1:0] clen;
    logic              bus_valid;
    logic [DW-1:0]     bus_data;
    logic [1:0]        bus_src;
    logic              bus_last;
    logic              bus_ready;
    logic [3:0]        beat_ack;
    logic [3:0]        done;
    logic              busy;
    logic              err;

    modport master (
        input  gnt, cdata, clen, bus_ready,
        output bus_valid, bus_data, bus_src, bus_last, beat_ack, done, busy, err
    );

    modport slave (
        output gnt, cdata, clen, bus_ready,
        input  bus_valid, bus_data, bus_src, bus_last, beat_ack, done, busy, err
    );
endinterface

// File: rtl/shared_bus_xfer.sv
// rtl/shared_bus_xfer.sv - moves a granted client's multi-beat burst onto a shared ready/valid bus
//
// Ports:
//   clk    clock, rising edge
//   n_rst  asynchronous active-low reset
//   xif    shared_bus_xfer_if.master (grant, client data/length, shared bus, acks, done, busy, err)
// Parameters: DW data width, LENW burst-length field width, TO_CYC stall timeout in cycles.
// Optional feature macro: XFER_TIMEOUT_EN enables the stall timeout abort.
module shared_bus_xfer #(
    parameter int DW     = 8,
    parameter int LENW   = 4,
    parameter int TO_CYC = 64
) (
    input  logic               clk,
    input  logic               n_rst,
    shared_bus_xfer_if.master  xif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      src;
    logic [LENW-1:0] cnt;
    logic [3:0]      done_r;
    logic            err_r;

    logic            gnt_onehot;
    logic            gnt_multi;
    logic [1:0]      gnt_idx;
    logic [LENW-1:0] clen_sel;
    logic [DW-1:0]   src_data;
    logic            in_xfer;
    logic            handshake;
    logic            timeout;

    // x & (x-1) clears the lowest set bit; zero result means at most one bit was set.
    assign gnt_onehot = (xif.gnt != 4'd0) && ((xif.gnt & (xif.gnt - 4'd1)) == 4'd0);
    assign gnt_multi  = (xif.gnt != 4'd0) && !gnt_onehot;

    always_comb begin
        gnt_idx = 2'd0;
        if (xif.gnt[1]) gnt_idx = 2'd1;
        if (xif.gnt[2]) gnt_idx = 2'd2;
        if (xif.gnt[3]) gnt_idx = 2'd3;
    end

    assign clen_sel  = xif.clen[int'(gnt_idx)*LENW +: LENW];
    assign src_data  = xif.cdata[int'(src)*DW +: DW];
    assign in_xfer   = (state == XFER);
    assign handshake = in_xfer && xif.bus_ready;

    assign xif.bus_valid = in_xfer;
    assign xif.bus_data  = in_xfer ? src_data : '0;
    assign xif.bus_src   = src;
    assign xif.bus_last  = in_xfer && (cnt == '0);
    assign xif.beat_ack  = handshake ? (4'b0001 << src) : 4'b0000;
    assign xif.busy      = (state != IDLE);
    assign xif.done      = done_r;
    assign xif.err       = err_r;

`ifdef XFER_TIMEOUT_EN
    localparam int SCW = $clog2(TO_CYC + 1);
    logic [SCW-1:0] stall_cnt;

    // Fires on the TO_CYC-th consecutive stalled cycle, i.e. when the counter would reach TO_CYC.
    assign timeout = in_xfer && !xif.bus_ready && (stall_cnt == SCW'(TO_CYC - 1));
`else
    wire [31:0] unused_to_cyc = 32'(TO_CYC);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            src    <= 2'd0;
            cnt    <= '0;
            done_r <= 4'd0;
            err_r  <= 1'b0;
`ifdef XFER_TIMEOUT_EN
            stall_cnt <= '0;
`endif
        end else begin
            done_r <= 4'd0;
            err_r  <= 1'b0;
`ifdef XFER_TIMEOUT_EN
            if (in_xfer && !xif.bus_ready && xif.gnt[src] && !timeout)
                stall_cnt <= stall_cnt + 1'b1;
            else
                stall_cnt <= '0;
`endif
            case (state)
                IDLE: begin
                    if (gnt_onehot) begin
                        src   <= gnt_idx;
                        cnt   <= clen_sel;
                        state <= XFER;
                    end else if (gnt_multi) begin
                        err_r <= 1'b1;
                    end
                end
                XFER: begin
                    // A last-beat handshake wins over a coincident grant drop or timeout.
                    if (handshake && (cnt == '0)) begin
                        state  <= DONE;
                        done_r <= 4'b0001 << src;
                    end else if (!xif.gnt[src] || timeout) begin
                        state <= IDLE;
                        err_r <= 1'b1;
                    end else if (handshake) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // One bubble cycle so the arbiter sees the request drop before regranting.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
